// File: rtl/instr_cache.sv
// instr_cache: direct-mapped instruction cache for the fetch stage.
//   Lookup is combinational (zero-cycle hit). On a miss the whole line is
//   refilled from instruction memory one word at a time over a
//   single-outstanding-request handshake, then the line is marked valid.
//
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   fetch_addr    16-bit word address from fetch (held stable while hit=0)
//   fetch_req     fetch wants an instruction this cycle
//   flush         invalidate all lines (single-cycle pulse)
//   instr_out     instruction at fetch_addr when hit=1, else 0
//   hit           instr_out valid this cycle
//   mem_req       refill read request (registered)
//   mem_addr      refill word address (registered)
//   mem_data      memory read data, qualified by mem_valid
//   mem_valid     memory returns mem_data for the current mem_addr
//   miss_count    saturating count of misses since reset
module instr_cache #(
  parameter int INDEX_BITS  = 4,
  parameter int OFFSET_BITS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] fetch_addr,
  input  logic        fetch_req,
  input  logic        flush,
  output logic [15:0] instr_out,
  output logic        hit,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_data,
  input  logic        mem_valid,
  output logic [15:0] miss_count
);

  localparam int TAG_BITS = 16 - INDEX_BITS - OFFSET_BITS;
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int WORDS    = 1 << OFFSET_BITS;
  localparam logic [OFFSET_BITS-1:0] CNT_ONE = 1;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_REFILL = 1'b1
  } state_t;

  state_t r_state, w_state_nxt;

  // Line storage: only the valid bits are reset.
  logic [LINES-1:0]    r_valid;
  logic [TAG_BITS-1:0] r_tag  [LINES];
  logic [15:0]         r_data [LINES][WORDS];

  // Refill bookkeeping
  logic [TAG_BITS-1:0]    r_cap_tag;
  logic [INDEX_BITS-1:0]  r_cap_idx;
  logic [OFFSET_BITS-1:0] r_cnt;
  logic                   r_flush_pend;
  logic                   r_mem_req;
  logic [15:0]            r_mem_addr;
  logic [15:0]            r_miss_count;

  // Address split and lookup
  logic [TAG_BITS-1:0]    w_tag;
  logic [INDEX_BITS-1:0]  w_idx;
  logic [OFFSET_BITS-1:0] w_off;
  logic                   w_lookup;
  logic                   w_match;
  logic                   w_hit;
  logic                   w_miss;
  logic                   w_xfer;
  logic                   w_last;

  assign w_tag = fetch_addr[15 -: TAG_BITS];
  assign w_idx = fetch_addr[OFFSET_BITS +: INDEX_BITS];
  assign w_off = fetch_addr[OFFSET_BITS-1:0];

  // A flush cycle neither hits nor starts a miss: the lines are being invalidated.
  assign w_lookup = fetch_req && (r_state == S_IDLE) && !flush;
  assign w_match  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_hit    = w_lookup && w_match;
  assign w_miss   = w_lookup && !w_match;

  assign w_xfer = (r_state == S_REFILL) && mem_valid;
  assign w_last = w_xfer && (r_cnt == '1);

  assign hit        = w_hit;
  assign instr_out  = w_hit ? r_data[w_idx][w_off] : '0;
  assign mem_req    = r_mem_req;
  assign mem_addr   = r_mem_addr;
  assign miss_count = r_miss_count;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_miss) w_state_nxt = S_REFILL;
      S_REFILL: if (w_last) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
      r_cnt        <= '0;
      r_miss_count <= '0;
      r_flush_pend <= 1'b0;
      r_valid      <= '0;
      r_cap_tag    <= '0;
      r_cap_idx    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE) begin
        if (flush) begin
          r_valid <= '0;
        end else if (w_miss) begin
          r_cap_tag    <= w_tag;
          r_cap_idx    <= w_idx;
          r_mem_addr   <= {w_tag, w_idx, {OFFSET_BITS{1'b0}}};
          r_mem_req    <= 1'b1;
          r_cnt        <= '0;
          r_flush_pend <= 1'b0;
          if (r_miss_count != '1) r_miss_count <= r_miss_count + 16'd1;
        end
      end else begin
        if (flush) r_flush_pend <= 1'b1;
        if (w_xfer) begin
          r_mem_addr <= r_mem_addr + 16'd1;
          r_cnt      <= r_cnt + CNT_ONE;
          if (w_last) begin
            r_mem_req    <= 1'b0;
            r_flush_pend <= 1'b0;
            // A flush seen at any point of the refill discards the new line too.
            if (flush || r_flush_pend) r_valid <= '0;
            else                       r_valid[r_cap_idx] <= 1'b1;
          end
        end
      end
    end
  end

  // Tag/data arrays carry no reset; writes only happen in REFILL, which reset leaves.
  always_ff @(posedge clk) begin
    if (w_xfer) r_data[r_cap_idx][r_cnt] <= mem_data;
    if (w_last) r_tag[r_cap_idx] <= r_cap_tag;
  end

endmodule

// File: tb/tb_instr_cache.sv
// tb_instr_cache: directed bench for instr_cache with a refill-address
// scoreboard and a memory responder with programmable wait states.
module tb_instr_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] fetch_addr;
  logic        fetch_req;
  logic        flush;
  logic [15:0] instr_out;
  logic        hit;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_valid;
  logic [15:0] miss_count;

  instr_cache #(.INDEX_BITS(4), .OFFSET_BITS(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_addr (fetch_addr),
    .fetch_req  (fetch_req),
    .flush      (flush),
    .instr_out  (instr_out),
    .hit        (hit),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_valid  (mem_valid),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  // Memory responder: answers after wait_cycles idle cycles per word.
  int wait_cycles = 0;
  int wcnt;
  assign mem_valid = mem_req && (wcnt == wait_cycles);
  assign mem_data  = 16'hA000 | mem_addr;

  always @(posedge clk or posedge rst) begin
    if (rst)                        wcnt <= 0;
    else if (mem_req && !mem_valid) wcnt <= wcnt + 1;
    else                            wcnt <= 0;
  end

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];
  int          held = 0;
  logic [15:0] held_addr;
  int          lat;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_line(input logic [15:0] addr);
    for (int i = 0; i < 4; i++) exp_q.push_back((addr & 16'hFFFC) + 16'(i));
  endtask

  // Sample at the falling edge; score every refill transfer against the queue.
  task automatic settle();
    logic [15:0] e;
    @(negedge clk);
    if (mem_req) begin
      if (held == 0) held_addr = mem_addr;
      else           chk("mem_addr_hold", mem_addr, held_addr);
      held++;
      if (mem_valid) begin
        chk("wait_len", held, wait_cycles + 1);
        chk("xfer_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("mem_addr_seq", mem_addr, e);
        end
        held = 0;
      end
    end else begin
      held = 0;
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hit(input int max, output int cycles);
    cycles = 0;
    while (cycles < max) begin
      adv();
      cycles++;
      settle();
      if (hit) break;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a request pending
    rst = 1'b1; fetch_req = 1'b1; fetch_addr = 16'h0000; flush = 1'b0;
    repeat (2) @(posedge clk);
    settle();
    chk("rst_hit", hit, 0);
    chk("rst_instr", instr_out, 16'h0000);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_miss_count", miss_count, 0);

    // Cold miss on 0x0012, zero-wait memory
    adv();
    rst = 1'b0; fetch_req = 1'b1; fetch_addr = 16'h0012;
    push_line(16'h0012);
    settle();
    chk("cold_miss_hit", hit, 0);
    wait_hit(20, lat);
    chk("cold_latency", lat, 5);
    chk("cold_hit", hit, 1);
    chk("cold_instr", instr_out, 16'hA012);
    chk("cold_miss_count", miss_count, 1);
    chk("cold_queue_empty", exp_q.size(), 0);

    // Line reuse on consecutive cycles
    adv(); fetch_addr = 16'h0010; settle();
    chk("reuse0_hit", hit, 1); chk("reuse0_instr", instr_out, 16'hA010); chk("reuse0_req", mem_req, 0);
    adv(); fetch_addr = 16'h0013; settle();
    chk("reuse1_hit", hit, 1); chk("reuse1_instr", instr_out, 16'hA013); chk("reuse1_req", mem_req, 0);
    adv(); fetch_addr = 16'h0011; settle();
    chk("reuse2_hit", hit, 1); chk("reuse2_instr", instr_out, 16'hA011); chk("reuse2_req", mem_req, 0);

    // Conflict miss with 3 wait cycles per word
    adv();
    wait_cycles = 3; fetch_addr = 16'h0052;
    push_line(16'h0052);
    settle();
    chk("conflict_miss_hit", hit, 0);
    wait_hit(40, lat);
    chk("conflict_latency", lat, 17);
    chk("conflict_instr", instr_out, 16'hA052);
    chk("conflict_miss_count", miss_count, 2);

    // Evicted line misses again
    adv();
    wait_cycles = 0; fetch_addr = 16'h0012;
    push_line(16'h0012);
    settle();
    chk("evicted_miss_hit", hit, 0);
    wait_hit(20, lat);
    chk("evicted_latency", lat, 5);
    chk("evicted_instr", instr_out, 16'hA012);
    chk("evicted_miss_count", miss_count, 3);

    // Flush pulse at t+2 of a refill of 0x0030
    adv(); fetch_addr = 16'h0030; push_line(16'h0030); settle();
    chk("flush_miss_hit", hit, 0);
    adv(); settle();
    adv(); flush = 1'b1; settle();
    adv(); flush = 1'b0; settle();
    adv(); settle();
    adv(); push_line(16'h0030); settle();
    chk("flush_after_hit", hit, 0);
    chk("flush_after_req", mem_req, 0);
    chk("flush_miss_count", miss_count, 4);
    chk("flush_queue", exp_q.size(), 4);
    wait_hit(20, lat);
    chk("flush_refetch_latency", lat, 5);
    chk("flush_refetch_instr", instr_out, 16'hA030);
    chk("flush_refetch_count", miss_count, 5);

    // Flush also dropped the other resident line
    adv(); fetch_addr = 16'h0012; push_line(16'h0012); settle();
    chk("flushed_line_hit", hit, 0);
    wait_hit(20, lat);
    chk("flushed_line_latency", lat, 5);
    chk("flushed_line_count", miss_count, 6);

    // Reset in the middle of a refill
    adv(); fetch_addr = 16'h0070; push_line(16'h0070); settle();
    chk("rstmid_miss_hit", hit, 0);
    adv(); settle();
    adv(); settle();
    rst = 1'b1;
    #1;
    chk("rstmid_mem_req", mem_req, 0);
    chk("rstmid_miss_count", miss_count, 0);
    exp_q.delete();
    held = 0;
    adv();
    rst = 1'b0; push_line(16'h0070);
    settle();
    chk("rstmid_refetch_hit", hit, 0);
    wait_hit(20, lat);
    chk("rstmid_latency", lat, 5);
    chk("rstmid_instr", instr_out, 16'hA070);
    chk("rstmid_count", miss_count, 1);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_cache.md
# instr_cache

Direct-mapped instruction cache that answers the fetch stage's instruction requests and produces the per-cycle instruction plus `hit` flag the IF/ID register carries. On a miss it stalls fetch by holding `hit` low. It then refills the whole line from instruction memory over a one-outstanding-request handshake, and serves the instruction once the line is valid.

## Interface
Parameters:
- `INDEX_BITS`, 4: line index width; the cache has 2^INDEX_BITS lines.
- `OFFSET_BITS`, 2: word-offset width; each line holds 2^OFFSET_BITS 16-bit words.

Tag width is 16 − INDEX_BITS − OFFSET_BITS. Addresses are 16-bit word addresses.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `fetch_addr`  in  16  PC from fetch; held stable by fetch while `hit`=0.
- `fetch_req`  in  1  fetch wants an instruction this cycle.
- `flush`  in  1  invalidate all lines (single-cycle pulse).
- `instr_out`  out  16  instruction at `fetch_addr` when `hit`=1, else 16'h0000.
- `hit`  out  1  `instr_out` is valid this cycle.
- `mem_req`  out  1  refill read request to instruction memory.
- `mem_addr`  out  16  refill word address, registered.
- `mem_data`  in  16  memory read data, valid with `mem_valid`.
- `mem_valid`  in  1  memory returns `mem_data` for the current `mem_addr`.
- `miss_count`  out  16  number of misses since reset, saturating at 16'hFFFF.

## Operation
- Address split: tag = addr[15:INDEX_BITS+OFFSET_BITS], index = next INDEX_BITS, offset = low OFFSET_BITS.
- Storage per line: valid bit, tag register, 2^OFFSET_BITS data words. Reset clears all valid bits only; tag and data contents are don't-care.
- Lookup is combinational: `hit` = `fetch_req` & state==IDLE & valid[index] & tag match. `instr_out` = data[index][offset] when `hit`, else 0.
- States:
  - IDLE: on `fetch_req` & !hit, capture tag/index. Set `mem_addr` = {tag, index, 0}, assert `mem_req`, increment `miss_count`, go to REFILL.
  - REFILL: `mem_req`=1, `mem_addr` stable until `mem_valid`. On `mem_valid`, write `mem_data` to word counter[OFFSET_BITS-1:0] and advance `mem_addr` by 1. On the last word, drop `mem_req` next cycle, write tag, set valid, go to IDLE.
- Refill uses the captured address. Changes on `fetch_addr` during REFILL do not affect it; lookup resumes with the current `fetch_addr` in IDLE.
- Flush handling:
  - `flush` in IDLE clears all valid bits at the next edge; `hit` is 0 in that cycle.
  - `flush` during REFILL is recorded. The refill completes its memory transfers, but the line is not validated, and all valid bits are cleared on return to IDLE.
- A conflict miss overwrites the resident line; there is no write path, so eviction has no writeback.
- `mem_valid` outside REFILL is ignored.

## Timing
- Reset values: state IDLE, `mem_req`=0, `mem_addr`=0, word counter 0, `miss_count`=0, pending-flush 0, all valid 0. Consequently `hit`=0 and `instr_out`=0.
- Reset mid-refill aborts immediately: `mem_req` drops asynchronously, and the partial line stays invalid.
- Hit latency: 0 cycles (same cycle as `fetch_req`).
- Miss penalty, miss detected in cycle t, with zero-wait memory (`mem_valid` high whenever `mem_req`):
  - `mem_req` rises at t+1.
  - Words transfer at t+1..t+4 (for OFFSET_BITS=2).
  - IDLE with the line valid at t+5; `hit`=1 at t+5.
- Each memory wait cycle adds one cycle to the penalty.
- `miss_count` updates at the edge that leaves IDLE, and holds at 16'hFFFF once saturated.

## Test plan
- Reset and idle: assert `rst` while `fetch_req`=1, addr 0x0000. Required: `hit`=0, `instr_out`=0, `mem_req`=0, `miss_count`=0.
- Cold miss: fetch 0x0012 with zero-wait memory returning 0xA000|addr. Required:
  - `mem_addr` sequence 0x0010, 0x0011, 0x0012, 0x0013 at t+1..t+4.
  - `hit`=1 with `instr_out`=0xA012 at t+5.
  - `miss_count`=1.
- Line reuse: after the cold miss, fetch 0x0010, 0x0013, 0x0011 on consecutive cycles. Required: `hit`=1 each cycle with 0xA010, 0xA013, 0xA011, and no `mem_req`.
- Conflict and wait states: fetch 0x0052 (same index, tag 1) with `mem_valid` delayed 3 cycles per word. Required:
  - `mem_addr` is held 4 cycles per word.
  - `hit` at t+17 with `instr_out`=0xA052.
  - A later fetch of 0x0012 misses again.
- Flush during refill: pulse `flush` at t+2 of a miss on 0x0030. Required: all 4 words are transferred, then IDLE, then `hit`=0 and a new miss on 0x0030.
- Reset mid-refill: assert `rst` at t+2. Required: `mem_req`=0 immediately, and the next fetch of the same address misses with `miss_count` restarting at 1.
